dac_spi_receiver: RTL and testbench



---
 rtl/dac_spi_receiver_pkg.sv | 26 ++
 rtl/dac_spi_receiver_sync_edge.sv | 43 ++++
 rtl/dac_spi_receiver.sv | 184 ++++++++++++++++++
 tb/tb_dac_spi_receiver.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_spi_receiver_pkg.sv
// dac_spi_pkg: types and constants shared by the DAC SPI receiver and the
// DPLL top that drives the real loop-filter DAC.
//   state_t        receiver FSM states
//   err_t / ERR_*  frame outcome codes reported on err_code
//   DAC_FRAME_BITS bits per DAC code frame
//   DAC_RESET_WORD DAC mid-lock code, used as the power-up word
package dac_spi_pkg;

  localparam int          DAC_FRAME_BITS = 16;
  localparam logic [15:0] DAC_RESET_WORD = 16'h8CCD;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    COMMIT = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  typedef logic [1:0] err_t;

  localparam err_t ERR_NONE    = 2'b00;
  localparam err_t ERR_SHORT   = 2'b01;
  localparam err_t ERR_LONG    = 2'b10;
  localparam err_t ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/dac_spi_receiver_sync_edge.sv
// spi_sync_edge: brings one asynchronous SPI pin into the CLOCK_50 domain
// through SYNC_STAGES flops, then one delay flop for edge detection.
//   CLOCK_50  system clock
//   reset     synchronous, active-low
//   din       asynchronous pin
//   level     synchronized level
//   rise/fall one-cycle pulses on synchronized transitions
// Every stage resets to 0, so a pin already high at reset release shows a
// rise and a pin already low shows nothing.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = sync_q[SYNC_STAGES-1] & ~dly_q;
  assign fall  = ~sync_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/dac_spi_receiver.sv
// dac_spi_receiver: SPI mode-0 target capturing 16-bit DAC code frames,
// oversampled on CLOCK_50.
//   CLOCK_50, reset           clock, synchronous active-low reset
//   spi_clk/spi_mosi/spi_cs_n asynchronous SPI pins
//   dac_word                  last accepted code (held)
//   word_valid                one-cycle pulse when dac_word updates
//   frame_err                 one-cycle pulse when a frame is rejected
//   err_code                  outcome of last frame (see dac_spi_pkg ERR_*)
//   frame_cnt                 accepted frame count, wraps
//   busy                      high whenever the FSM is not IDLE
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a CS_n fall; all other pin edges ignored
// ACTIVE | shifting bits on SCLK rises, watching CS_n rise and timeout
// COMMIT | one cycle: publish shift register as dac_word
// DRAIN  | frame timed out; wait for CS_n rise without a second error
module dac_spi_receiver
  import dac_spi_pkg::*;
#(
  parameter int          FRAME_BITS  = DAC_FRAME_BITS,
  parameter int          SYNC_STAGES = 2,
  parameter int          TIMEOUT_CYC = 4096,
  parameter logic [15:0] RESET_WORD  = DAC_RESET_WORD
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  spi_clk,
  input  logic                  spi_mosi,
  input  logic                  spi_cs_n,
  output logic [FRAME_BITS-1:0] dac_word,
  output logic                  word_valid,
  output logic                  frame_err,
  output logic [1:0]            err_code,
  output logic [15:0]           frame_cnt,
  output logic                  busy
);

  localparam int             TMO_W    = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [4:0]     CNT_FULL = 5'(FRAME_BITS);
  localparam logic [4:0]     CNT_SAT  = 5'(FRAME_BITS + 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .din      (spi_clk),
    .level    (sclk_lvl),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .din      (spi_cs_n),
    .level    (cs_lvl),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .din      (spi_mosi),
    .level    (mosi_lvl),
    .rise     (mosi_rise),
    .fall     (mosi_fall)
  );

  // Only MOSI level, SCLK rise and CS_n edges drive the FSM.
  logic sync_unused;
  assign sync_unused = &{1'b0, sclk_lvl, sclk_fall, cs_lvl, mosi_rise, mosi_fall};

  state_t                state_q, state_d;
  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [FRAME_BITS-1:0] dac_word_q, dac_word_d;
  logic                  word_valid_q, word_valid_d;
  logic                  frame_err_q, frame_err_d;
  err_t                  err_code_q, err_code_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    tmo_d        = tmo_q;
    shift_d      = shift_q;
    dac_word_d   = dac_word_q;
    word_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    err_code_d   = err_code_q;
    frame_cnt_d  = frame_cnt_q;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = ACTIVE;
          bit_cnt_d = '0;
          tmo_d     = '0;
          shift_d   = '0;
        end
      end

      ACTIVE: begin
        // CS_n rise has priority over a coincident SCLK rise or timeout.
        if (cs_rise) begin
          if (bit_cnt_q == CNT_FULL) begin
            state_d = COMMIT;
          end else begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
            err_code_d  = (bit_cnt_q < CNT_FULL) ? ERR_SHORT : ERR_LONG;
          end
        end else if (sclk_rise) begin
          shift_d = {shift_q[FRAME_BITS-2:0], mosi_lvl};
          if (bit_cnt_q != CNT_SAT) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
          tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d     = DRAIN;
          frame_err_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      COMMIT: begin
        state_d      = IDLE;
        dac_word_d   = shift_q;
        word_valid_d = 1'b1;
        err_code_d   = ERR_NONE;
        frame_cnt_d  = frame_cnt_q + 16'd1;
      end

      DRAIN: begin
        if (cs_rise) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      tmo_q        <= '0;
      shift_q      <= '0;
      dac_word_q   <= RESET_WORD[FRAME_BITS-1:0];
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      tmo_q        <= tmo_d;
      shift_q      <= shift_d;
      dac_word_q   <= dac_word_d;
      word_valid_q <= word_valid_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign dac_word   = dac_word_q;
  assign word_valid = word_valid_q;
  assign frame_err  = frame_err_q;
  assign err_code   = err_code_q;
  assign frame_cnt  = frame_cnt_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dac_spi_receiver.sv
// Bench for dac_spi_receiver: directed and random SPI frames against a
// frame-level model (count the bits, first 16 bits form the word).
module tb_dac_spi_receiver;
  import dac_spi_pkg::*;

  localparam int SYNC = 2;
  localparam int TMO  = 4096;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b0;
  logic        spi_clk  = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic [15:0] dac_word;
  logic        word_valid;
  logic        frame_err;
  logic [1:0]  err_code;
  logic [15:0] frame_cnt;
  logic        busy;

  dac_spi_receiver #(
    .FRAME_BITS  (16),
    .SYNC_STAGES (SYNC),
    .TIMEOUT_CYC (TMO),
    .RESET_WORD  (16'h8CCD)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_cs_n   (spi_cs_n),
    .dac_word   (dac_word),
    .word_valid (word_valid),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .frame_cnt  (frame_cnt),
    .busy       (busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;
  int wv_seen = 0, fe_seen = 0, both_seen = 0;

  // expected model state
  logic [15:0] exp_word = 16'h8CCD;
  logic [15:0] exp_cnt  = 16'h0000;
  logic [1:0]  exp_err  = 2'b00;
  int          exp_wv   = 0;
  int          exp_fe   = 0;

  always @(negedge CLOCK_50) begin
    if (word_valid) wv_seen++;
    if (frame_err) fe_seen++;
    if (word_valid && frame_err) both_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance n rising edges, then settle 2 ns past the edge for driving
  task automatic cyc(input int n);
    if (n > 0) begin
      repeat (n) @(posedge CLOCK_50);
      #2;
    end
  endtask

  // clock out bits data[31-start] .. ; optional gap after the 8th bit;
  // coincide raises CS_n together with the final SCLK rise
  task automatic clock_bits(input logic [31:0] data, input int start, input int n,
                            input int half, input int gap8, input bit coincide);
    for (int i = start; i < start + n; i++) begin
      spi_mosi = data[31-i];
      cyc(half);
      spi_clk = 1'b1;
      if (coincide && i == start + n - 1) spi_cs_n = 1'b1;
      cyc(half);
      spi_clk = 1'b0;
      if (i == 7 && gap8 > 0) cyc(gap8);
    end
    cyc(half);
  endtask

  task automatic open_frame();
    spi_cs_n = 1'b0;
    cyc(4);
  endtask

  // model: a frame ending with a CS_n rise after 'counted' SCLK rises
  task automatic model_frame(input logic [31:0] data, input int counted);
    if (counted == 16) begin
      exp_word = data[31:16];
      exp_cnt  = exp_cnt + 16'd1;
      exp_err  = ERR_NONE;
      exp_wv++;
    end else begin
      exp_err = (counted < 16) ? ERR_SHORT : ERR_LONG;
      exp_fe++;
    end
  endtask

  task automatic check_state(input string tag);
    @(negedge CLOCK_50);
    chk({tag, ".dac_word"},  {16'h0, dac_word},  {16'h0, exp_word});
    chk({tag, ".err_code"},  {30'h0, err_code},  {30'h0, exp_err});
    chk({tag, ".frame_cnt"}, {16'h0, frame_cnt}, {16'h0, exp_cnt});
    chk({tag, ".busy"},      {31'h0, busy},      32'h0);
    chk({tag, ".wv_pulses"}, wv_seen, exp_wv);
    chk({tag, ".fe_pulses"}, fe_seen, exp_fe);
    @(posedge CLOCK_50);
    #2;
  endtask

  task automatic full_frame(input string tag, input logic [31:0] data, input int nbits,
                            input int half, input int gap8);
    open_frame();
    clock_bits(data, 0, nbits, half, gap8, 1'b0);
    spi_cs_n = 1'b1;
    cyc(12);
    model_frame(data, nbits);
    check_state(tag);
  endtask

  initial begin
    logic [31:0] d;
    int n;

    // reset with CS_n idle high
    reset = 1'b0;
    cyc(5);
    @(negedge CLOCK_50);
    chk("rst.dac_word",   {16'h0, dac_word},  32'h8CCD);
    chk("rst.word_valid", {31'h0, word_valid}, 32'h0);
    chk("rst.frame_err",  {31'h0, frame_err}, 32'h0);
    chk("rst.err_code",   {30'h0, err_code},  32'h0);
    chk("rst.frame_cnt",  {16'h0, frame_cnt}, 32'h0);
    chk("rst.busy",       {31'h0, busy},      32'h0);
    @(posedge CLOCK_50);
    #2;
    reset = 1'b1;
    cyc(10);
    check_state("post_rst");

    // 1: 0x8CCE, half-period 4, 550-cycle inter-byte gap, latency check
    d = 32'h8CCE_0000;
    open_frame();
    clock_bits(d, 0, 16, 4, 550, 1'b0);
    chk("t1.busy_active", {31'h0, busy}, 32'h1);
    spi_cs_n = 1'b1;
    repeat (SYNC + 1) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("t1.wv_early", {31'h0, word_valid}, 32'h0);
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("t1.wv_on_time", {31'h0, word_valid}, 32'h1);
    chk("t1.word_at_valid", {16'h0, dac_word}, 32'h8CCE);
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("t1.wv_one_cycle", {31'h0, word_valid}, 32'h0);
    cyc(8);
    model_frame(d, 16);
    check_state("t1");

    // 2: short frame, 12 bits
    full_frame("t2", {$urandom} & 32'hFFF0_0000, 12, 3, 0);

    // 3: long frame, 17 ones
    full_frame("t3", 32'hFFFF_8000, 17, 2, 0);

    // 4: 8 bits then stall -> timeout, DRAIN until CS_n high
    d = 32'hA700_0000;
    open_frame();
    clock_bits(d, 0, 8, 4, 0, 1'b0);
    n = 0;
    while (!frame_err && n < 6000) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("t4.timeout_window", {31'h0, (n >= TMO - 8 && n <= TMO)}, 32'h1);
    chk("t4.err_timeout", {30'h0, err_code}, {30'h0, ERR_TIMEOUT});
    chk("t4.busy_drain", {31'h0, busy}, 32'h1);
    exp_err = ERR_TIMEOUT;
    exp_fe++;
    @(posedge CLOCK_50);
    #2;
    clock_bits(32'hFFFF_FFFF, 0, 3, 2, 0, 1'b0);
    chk("t4.busy_still", {31'h0, busy}, 32'h1);
    spi_cs_n = 1'b1;
    cyc(12);
    check_state("t4_drain");
    full_frame("t4_next", 32'h1234_0000, 16, 3, 0);

    // 5: reset after 5 bits, released with CS_n low, then 11 more bits
    d = 32'h5A5A_0000;
    open_frame();
    clock_bits(d, 0, 5, 3, 0, 1'b0);
    reset = 1'b0;
    cyc(4);
    reset = 1'b1;
    exp_word = 16'h8CCD;
    exp_cnt  = 16'h0000;
    exp_err  = ERR_NONE;
    cyc(4);
    clock_bits(d, 5, 11, 3, 0, 1'b0);
    spi_cs_n = 1'b1;
    cyc(12);
    check_state("t5_partial");
    full_frame("t5_next", 32'hA5A5_0000, 16, 4, 0);

    // random frames
    for (int k = 0; k < 6; k++) begin
      int nb;
      nb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(8, 20)) : 16;
      full_frame("rand", $urandom, nb, $urandom_range(2, 5), $urandom_range(0, 600));
    end

    // 6a: CS_n rise coincident with the 16th SCLK rise -> short
    d = $urandom;
    open_frame();
    clock_bits(d, 0, 16, 3, 0, 1'b1);
    cyc(12);
    model_frame(d, 15);
    check_state("t6_coincide");

    // 6b: frame counter wrap
    force dut.frame_cnt_q = 16'hFFFF;
    @(posedge CLOCK_50);
    #2;
    release dut.frame_cnt_q;
    exp_cnt = 16'hFFFF;
    cyc(2);
    @(negedge CLOCK_50);
    chk("t6.cnt_forced", {16'h0, frame_cnt}, 32'hFFFF);
    cyc(1);
    full_frame("t6_wrap", 32'h0F0F_0000, 16, 2, 0);

    chk("never_both", both_seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
